multicycle_ctrl: RTL

//  Multi-cycle control FSM for the RV32I core. It replaces the single-cycle control unit when

---
 rtl/multicycle_ctrl.sv | 292 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Multi-cycle control FSM for an RV32I core whose instruction and data
//   accesses share one memory port with a ready handshake. It sequences fetch,
//   decode, execute, memory and writeback. It drives the datapath muxes and
//   strobes, and it counts retired instructions.
//
//   Ports
//     clk, reset            rising-edge clock, asynchronous active-low reset
//     op, func3, func7      instruction fields taken from the IR
//     zero                  ALU result == 0 (branch condition)
//     mem_ready             memory completes the access this cycle
//     mem_req, adrSrc       memory request and address select (0 PC, 1 result)
//     memWrite              store strobe (only while mem_ready)
//     irWrite, pcWrite      IR/oldPC load and PC load
//     regWrite              register file write enable
//     resultSrc, aluSrcA,
//     aluSrcB, aluControl,
//     immSrc                datapath mux / ALU / immediate selects
//     instret               retired-instruction counter (wraps)
//     err                   sticky memory-timeout / trap flag
//
//   Build option
//     ILLEGAL_TRAP_EN       if defined, an unlisted opcode in DECODE goes to
//                           ERROR. Otherwise the instruction retires as a NOP.
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       func3,
    input  logic             func7,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             adrSrc,
    output logic             memWrite,
    output logic             irWrite,
    output logic             pcWrite,
    output logic             regWrite,
    output logic [1:0]       resultSrc,
    output logic [1:0]       aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [2:0]       aluControl,
    output logic [1:0]       immSrc,
    output logic [CNT_W-1:0] instret,
    output logic             err
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // Last count value before the limit: one more unanswered cycle times out.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_BOOT     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10,
        S_JAL      = 4'd11,
        S_ERROR    = 4'd12
    } state_e;

    // Registered control word. The strobes that must follow mem_ready or zero
    // within the same cycle are stored as enables and gated at the output.
    typedef struct packed {
        logic       mem_req;
        logic       adr_src;
        logic       fetch_wr;    // irWrite/pcWrite enable in FETCH
        logic       pc_jump;     // unconditional pcWrite
        logic       pc_branch;   // pcWrite = zero
        logic       mem_wr_en;   // memWrite enable in MEMWRITE
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [1:0] imm_src;
        logic       trap;
    } ctrl_t;

    state_e             state_q, state_d;
    ctrl_t              ctrl_q;
    logic [7:0]         to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0]   instret_q;
    logic               mem_wait_s;
    logic               timeout_s;
    logic               retire_s;

    // ALU operation for EXECR/EXECI. func7 selects sub only for R-type.
    function automatic logic [2:0] alu_decode(input logic [2:0] f3,
                                              input logic       f7,
                                              input logic       is_rtype);
        logic [2:0] ctl;
        case (f3)
            3'b000:  ctl = (is_rtype && f7) ? 3'b001 : 3'b000;
            3'b010:  ctl = 3'b101;
            3'b110:  ctl = 3'b011;
            3'b111:  ctl = 3'b010;
            default: ctl = 3'b000;
        endcase
        return ctl;
    endfunction

    // Moore control word for a state. The instruction fields are stable in the IR.
    function automatic ctrl_t ctrl_decode(input state_e     st,
                                          input logic [6:0] op_v,
                                          input logic [2:0] f3,
                                          input logic       f7);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.fetch_wr   = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
                c.imm_src   = 2'b10;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.imm_src   = (op_v == OP_STORE) ? 2'b01 : 2'b00;
            end
            S_MEMREAD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.mem_req   = 1'b1;
                c.adr_src   = 1'b1;
                c.mem_wr_en = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a   = 2'b10;
                c.alu_src_b   = 2'b00;
                c.alu_control = alu_decode(f3, f7, 1'b1);
            end
            S_EXECI: begin
                c.alu_src_a   = 2'b10;
                c.alu_src_b   = 2'b01;
                c.imm_src     = 2'b00;
                c.alu_control = alu_decode(f3, f7, 1'b0);
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a   = 2'b10;
                c.alu_control = 3'b001;
                c.pc_branch   = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.imm_src   = 2'b11;
                c.pc_jump   = 1'b1;
            end
            S_ERROR: begin
                c.trap = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

    // An unanswered request cycle. The one that would reach the limit causes a timeout.
    always_comb begin
        mem_wait_s = ctrl_q.mem_req & ~mem_ready;
        timeout_s  = mem_wait_s & (to_cnt_q == TO_LAST);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:     state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready)      state_d = S_DECODE;
                else if (timeout_s) state_d = S_ERROR;
                else                state_d = S_FETCH;
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD:  state_d = S_MEMADR;
                    OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE: state_d = S_EXECR;
                    OP_ITYPE: state_d = S_EXECI;
                    OP_BEQ:   state_d = S_BEQ;
                    OP_JAL:   state_d = S_JAL;
`ifdef ILLEGAL_TRAP_EN
                    default:  state_d = S_ERROR;
`else
                    default:  state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                if (op == OP_STORE) state_d = S_MEMWRITE;
                else                state_d = S_MEMREAD;
            end
            S_MEMREAD: begin
                if (mem_ready)      state_d = S_MEMWB;
                else if (timeout_s) state_d = S_ERROR;
                else                state_d = S_MEMREAD;
            end
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ready)      state_d = S_FETCH;
                else if (timeout_s) state_d = S_ERROR;
                else                state_d = S_MEMWRITE;
            end
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_ERROR:    state_d = S_ERROR;
            default:    state_d = S_ERROR;
        endcase
    end

    // The timeout count restarts on every state change, so each request state starts at zero.
    always_comb begin
        if (state_d != state_q) begin
            to_cnt_d = 8'd0;
        end else if (mem_wait_s) begin
            to_cnt_d = to_cnt_q + 8'd1;
        end else begin
            to_cnt_d = to_cnt_q;
        end
        retire_s = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_BOOT);
    end

    // State, registered control word, timeout counter and instret.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_BOOT;
            ctrl_q    <= '0;
            to_cnt_q  <= 8'd0;
            instret_q <= '0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_decode(state_d, op, func3, func7);
            to_cnt_q <= to_cnt_d;
            if (retire_s) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign mem_req    = ctrl_q.mem_req;
    assign adrSrc     = ctrl_q.adr_src;
    assign memWrite   = ctrl_q.mem_wr_en & mem_ready;
    assign irWrite    = ctrl_q.fetch_wr & mem_ready;
    assign pcWrite    = (ctrl_q.fetch_wr & mem_ready) | ctrl_q.pc_jump
                      | (ctrl_q.pc_branch & zero);
    assign regWrite   = ctrl_q.reg_write;
    assign resultSrc  = ctrl_q.result_src;
    assign aluSrcA    = ctrl_q.alu_src_a;
    assign aluSrcB    = ctrl_q.alu_src_b;
    assign aluControl = ctrl_q.alu_control;
    assign immSrc     = ctrl_q.imm_src;
    assign instret    = instret_q;
    assign err        = ctrl_q.trap;

endmodule
